// File: rtl/framebuffer_screen_arbiter_if.sv
// ----------------------------------------------------------------------------
// framebuffer_screen_arbiter_if
//   Bundles the drawing-source write bus and the registered framebuffer write
//   port of framebuffer_screen_arbiter.
//
//   Signals
//     src_req    [NUM_SRC]          per-source write request
//     src_addr   [NUM_SRC*ADDR_W]   packed addresses, source i at [i*ADDR_W +: ADDR_W]
//     src_data   [NUM_SRC*DATA_W]   packed pixels, same packing
//     src_ack    [NUM_SRC]          write accepted this cycle
//     src_active [NUM_SRC]          one-hot enable to the selected source
//     fb_we/fb_addr/fb_data         registered framebuffer write port
//
//   Modports
//     master : the drawing-source side (drives requests, observes acks and fb)
//     slave  : the arbiter
// ----------------------------------------------------------------------------
interface framebuffer_screen_arbiter_if #(
    parameter int NUM_SRC = 6,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 12
);
    logic [NUM_SRC-1:0]        src_req;
    logic [NUM_SRC*ADDR_W-1:0] src_addr;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_ack;
    logic [NUM_SRC-1:0]        src_active;
    logic                      fb_we;
    logic [ADDR_W-1:0]         fb_addr;
    logic [DATA_W-1:0]         fb_data;

    modport master (
        output src_req, src_addr, src_data,
        input  src_ack, src_active, fb_we, fb_addr, fb_data
    );

    modport slave (
        input  src_req, src_addr, src_data,
        output src_ack, src_active, fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/framebuffer_screen_arbiter.sv
// ----------------------------------------------------------------------------
// framebuffer_screen_arbiter
//   Selects which drawing source (menu frames, pong, snake, dino) owns the
//   framebuffer. PS/2 make codes walk a screen FSM; every screen change wipes
//   the framebuffer (one zero write per cycle) before the newly selected
//   source is granted the write port.
//
//   Ports
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     key_code   PS/2 make scancode
//     key_valid  one-cycle strobe qualifying key_code
//     bus        source request bus + framebuffer write port (slave modport)
//     screen     current screen code (F1=0 F2=1 F3=2 PONG=3 SNAKE=4 DINO=5)
//     busy_clear high while the framebuffer is being cleared
//     range_err  sticky: an accepted write had an address >= FB_DEPTH
// ----------------------------------------------------------------------------
module framebuffer_screen_arbiter #(
    parameter int NUM_SRC  = 6,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 12,
    parameter int FB_DEPTH = 307200
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [7:0]                         key_code,
    input  logic                               key_valid,
    framebuffer_screen_arbiter_if.slave        bus,
    output logic [2:0]                         screen,
    output logic                               busy_clear,
    output logic                               range_err
);
    localparam int              CNT_W    = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FB_DEPTH - 1);
    localparam logic [31:0]     DEPTH_U  = 32'(FB_DEPTH);

    // PS/2 set-2 make codes
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_ENTER = 8'h5A;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_Z     = 8'h1A;
    localparam logic [7:0] KEY_ESC   = 8'h76;
    localparam logic [7:0] KEY_R     = 8'h2D;

    typedef enum logic [2:0] {
        SCR_F1    = 3'd0,
        SCR_F2    = 3'd1,
        SCR_F3    = 3'd2,
        SCR_PONG  = 3'd3,
        SCR_SNAKE = 3'd4,
        SCR_DINO  = 3'd5
    } screen_e;

    typedef enum logic {MODE_CLEAR, MODE_RUN} mode_e;

    screen_e           screen_q, screen_d;
    mode_e             mode_q,   mode_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              fb_we_q,  fb_we_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [DATA_W-1:0] fb_data_q, fb_data_d;
    logic              range_err_q, range_err_d;

    logic              run;
    logic              sel_req;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              in_range;
    logic [NUM_SRC-1:0] ack, active;

    assign run = (mode_q == MODE_RUN);

    // Grant: only the source whose index equals the screen code is enabled,
    // and only outside of a clear.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned -- that is what keeps latches from being inferred.
        ack      = '0;
        active   = '0;
        sel_req  = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (run && i == int'(screen_q)) begin
                active[i] = 1'b1;
                ack[i]    = bus.src_req[i];
                sel_req   = bus.src_req[i];
                sel_addr  = bus.src_addr[i*ADDR_W +: ADDR_W];
                sel_data  = bus.src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign in_range = (32'(sel_addr) < DEPTH_U);

    // Screen / mode next-state and framebuffer write port next-state.
    always_comb begin
        screen_d    = screen_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        fb_we_d     = 1'b0;
        fb_addr_d   = '0;
        fb_data_d   = '0;
        range_err_d = range_err_q;

        if (key_valid) begin
            case (screen_q)
                SCR_F1: begin
                    if (key_code == KEY_S)          screen_d = SCR_F2;
                    else if (key_code == KEY_ENTER) screen_d = SCR_PONG;
                end
                SCR_F2: begin
                    if (key_code == KEY_A)          screen_d = SCR_F1;
                    else if (key_code == KEY_Z)     screen_d = SCR_F3;
                    else if (key_code == KEY_ENTER) screen_d = SCR_SNAKE;
                end
                SCR_F3: begin
                    if (key_code == KEY_S)          screen_d = SCR_F2;
                    else if (key_code == KEY_ENTER) screen_d = SCR_DINO;
                end
                SCR_PONG:  if (key_code == KEY_ESC) screen_d = SCR_F1;
                SCR_SNAKE: if (key_code == KEY_ESC) screen_d = SCR_F2;
                SCR_DINO:  if (key_code == KEY_ESC) screen_d = SCR_F3;
                default: ;
            endcase
            // Home key overrides every other transition.
            if (key_code == KEY_R) screen_d = SCR_F1;
        end

        // Codes 6/7 are never produced; recover to F1 (which also clears).
        if (screen_q > SCR_DINO) screen_d = SCR_F1;

        if (screen_d != screen_q) begin
            // Any change, including one on the last clear cycle, restarts the wipe.
            mode_d = MODE_CLEAR;
            cnt_d  = '0;
        end else if (mode_q == MODE_CLEAR) begin
            if (cnt_q == CNT_LAST) begin
                mode_d = MODE_RUN;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // The write issued this cycle is registered onto the fb port.
        if (mode_q == MODE_CLEAR) begin
            fb_we_d   = 1'b1;
            fb_addr_d = ADDR_W'(cnt_q);
        end else if (sel_req) begin
            if (in_range) begin
                fb_we_d   = 1'b1;
                fb_addr_d = sel_addr;
                fb_data_d = sel_data;
            end else begin
                range_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            screen_q    <= SCR_F1;
            mode_q      <= MODE_CLEAR;
            cnt_q       <= '0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            range_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            screen_q    <= screen_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_data_q   <= fb_data_d;
            range_err_q <= range_err_d;
        end
    end

    assign bus.src_ack    = ack;
    assign bus.src_active = active;
    assign bus.fb_we      = fb_we_q;
    assign bus.fb_addr    = fb_addr_q;
    assign bus.fb_data    = fb_data_q;
    assign screen         = screen_q;
    assign busy_clear     = (mode_q == MODE_CLEAR);
    assign range_err      = range_err_q;

endmodule
